// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall decision for the decode stage of a 5-stage MIPS pipe.
// Compares D-stage source registers (with their Tuse) against E/M destination
// registers (with their Tnew). Also tracks the mult/div busy window with a
// 4-bit down-counter. On a stall, PC and F/D are frozen and D/E is cleared.
// Optional feature: define STALL_STATS_EN to add the stall_cnt statistics port.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic [31:0] instr_m,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_clr,
`ifdef STALL_STATS_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        md_busy
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  // Field extraction. Only some fields matter per stage; the remaining bits are
  // gathered into a reduction so the whole instruction word counts as consumed.
  logic [5:0] op_d, fn_d, op_e, fn_e, op_m, fn_m;
  logic [4:0] rs_d, rt_d;
  logic       unused_bits;

  assign op_d = instr_d[31:26];
  assign fn_d = instr_d[5:0];
  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];
  assign op_e = instr_e[31:26];
  assign fn_e = instr_e[5:0];
  assign op_m = instr_m[31:26];
  assign fn_m = instr_m[5:0];
  assign unused_bits = ^{instr_d, instr_e, instr_m};

  // Destination register of a producer; 0 means "no destination".
  function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] rt, input logic [4:0] rd);
    logic [4:0] r;
    r = 5'd0;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU || fn == FN_MFHI || fn == FN_MFLO) r = rd;
      end
      OP_ORI, OP_LUI, OP_LW: r = rt;
      OP_JAL:                r = 5'd31;
      default:               r = 5'd0;
    endcase
    return r;
  endfunction

  // Cycles until a producer sitting in E has its result available.
  function automatic logic [1:0] tnew_in_e(input logic [5:0] op, input logic [5:0] fn);
    logic [1:0] t;
    t = 2'd0;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU || fn == FN_MFHI || fn == FN_MFLO) t = 2'd1;
      end
      OP_ORI, OP_LUI: t = 2'd1;
      OP_LW:          t = 2'd2;
      default:        t = 2'd0;
    endcase
    return t;
  endfunction

  // A source stalls when it names a live non-zero producer that is not ready in time.
  function automatic logic hazard(input logic use_src, input logic [4:0] src,
                                  input logic [1:0] tuse, input logic [4:0] dst,
                                  input logic [1:0] tnew);
    return use_src && (dst != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  logic       rs_use_d, rt_use_d, md_class_d;
  logic [1:0] rs_tuse_d, rt_tuse_d;

  // Decode which sources the D instruction reads and when it needs them.
  always_comb begin
    rs_use_d   = 1'b0;
    rs_tuse_d  = 2'd0;
    rt_use_d   = 1'b0;
    rt_tuse_d  = 2'd0;
    md_class_d = 1'b0;
    case (op_d)
      OP_RTYPE: begin
        case (fn_d)
          FN_ADDU, FN_SUBU: begin
            rs_use_d = 1'b1; rs_tuse_d = 2'd1;
            rt_use_d = 1'b1; rt_tuse_d = 2'd1;
          end
          FN_JR: begin
            rs_use_d = 1'b1; rs_tuse_d = 2'd0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            rs_use_d = 1'b1; rs_tuse_d = 2'd1;
            rt_use_d = 1'b1; rt_tuse_d = 2'd1;
            md_class_d = 1'b1;
          end
          FN_MFHI, FN_MFLO: md_class_d = 1'b1;
          FN_MTHI, FN_MTLO: begin
            rs_use_d = 1'b1; rs_tuse_d = 2'd1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LW: begin
        rs_use_d = 1'b1; rs_tuse_d = 2'd1;
      end
      OP_SW: begin
        rs_use_d = 1'b1; rs_tuse_d = 2'd1;
        rt_use_d = 1'b1; rt_tuse_d = 2'd2;
      end
      OP_BEQ: begin
        rs_use_d = 1'b1; rs_tuse_d = 2'd0;
        rt_use_d = 1'b1; rt_tuse_d = 2'd0;
      end
      OP_J, OP_JAL, OP_LUI: ;
      default: ;
    endcase
  end

  logic [4:0] dst_e, dst_m;
  logic [1:0] tnew_e, tnew_m;
  logic       md_start, md_is_div;
  logic       data_stall, md_stall, stall;
  logic [3:0] cnt_q, cnt_d;

  assign dst_e  = dest_reg(op_e, fn_e, instr_e[20:16], instr_e[15:11]);
  assign tnew_e = tnew_in_e(op_e, fn_e);
  assign dst_m  = dest_reg(op_m, fn_m, instr_m[20:16], instr_m[15:11]);
  assign tnew_m = {1'b0, (op_m == OP_LW)};

  assign md_start  = (op_e == OP_RTYPE) &&
                     (fn_e == FN_MULT || fn_e == FN_MULTU || fn_e == FN_DIV || fn_e == FN_DIVU);
  assign md_is_div = fn_e[1];

  assign md_busy = (cnt_q != 4'd0);

  assign data_stall = hazard(rs_use_d, rs_d, rs_tuse_d, dst_e, tnew_e) |
                      hazard(rt_use_d, rt_d, rt_tuse_d, dst_e, tnew_e) |
                      hazard(rs_use_d, rs_d, rs_tuse_d, dst_m, tnew_m) |
                      hazard(rt_use_d, rt_d, rt_tuse_d, dst_m, tnew_m);
  assign md_stall   = md_class_d && (md_start || md_busy);
  assign stall      = data_stall | md_stall;

  assign pc_en    = ~stall;
  assign ifid_en  = ~stall;
  assign idex_clr = stall;

  // Busy counter next state: a start reloads (even if already busy), else count down.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start)             cnt_d = md_is_div ? DIV_LD : MULT_LD;
    else if (cnt_q != 4'd0)   cnt_d = cnt_q - 4'd1;
  end

  // Busy counter register; reset discards any pending mult/div.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Statistics register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios then random instruction mixes,
// compared against an instruction-level model of Tuse/Tnew and the mult/div window.
module tb_hazard_stall_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  typedef enum int {
    NOP, ADDU, SUBU, ORI, LUI, LW, SW, BEQ, J, JAL, JR,
    MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, UNK
  } op_e;

  typedef struct {
    op_e        op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } inst_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'd0;
  logic [31:0] instr_e = 32'd0;
  logic [31:0] instr_m = 32'd0;
  logic        pc_en, ifid_en, idex_clr, md_busy;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_left = 0;
  int unsigned stats_m = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .instr_d  (instr_d),
    .instr_e  (instr_e),
    .instr_m  (instr_m),
    .pc_en    (pc_en),
    .ifid_en  (ifid_en),
    .idex_clr (idex_clr),
`ifdef STALL_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .md_busy  (md_busy)
  );

  function automatic inst_t mk(op_e op, int rs, int rt, int rd);
    inst_t i;
    i.op = op; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    return i;
  endfunction

  function automatic logic [31:0] enc(inst_t i);
    case (i.op)
      ADDU:  return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h21};
      SUBU:  return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h23};
      ORI:   return {6'h0D, i.rs, i.rt, 16'h1234};
      LUI:   return {6'h0F, 5'd0, i.rt, 16'hBEEF};
      LW:    return {6'h23, i.rs, i.rt, 16'h0004};
      SW:    return {6'h2B, i.rs, i.rt, 16'h0008};
      BEQ:   return {6'h04, i.rs, i.rt, 16'h0003};
      J:     return {6'h02, 26'h0000040};
      JAL:   return {6'h03, 26'h0000080};
      JR:    return {6'h00, i.rs, 15'd0, 6'h08};
      MULT:  return {6'h00, i.rs, i.rt, 10'd0, 6'h18};
      MULTU: return {6'h00, i.rs, i.rt, 10'd0, 6'h19};
      DIV:   return {6'h00, i.rs, i.rt, 10'd0, 6'h1A};
      DIVU:  return {6'h00, i.rs, i.rt, 10'd0, 6'h1B};
      MFHI:  return {6'h00, 10'd0, i.rd, 5'd0, 6'h10};
      MFLO:  return {6'h00, 10'd0, i.rd, 5'd0, 6'h12};
      MTHI:  return {6'h00, i.rs, 15'd0, 6'h11};
      MTLO:  return {6'h00, i.rs, 15'd0, 6'h13};
      UNK:   return {6'h08, i.rs, i.rt, 16'h0001};
      default: return 32'd0;
    endcase
  endfunction

  // Reference rules, expressed per mnemonic; -1 means the operand is not read.
  function automatic int rs_tuse(op_e op);
    case (op)
      BEQ, JR: return 0;
      ADDU, SUBU, ORI, LW, SW, MULT, MULTU, DIV, DIVU, MTHI, MTLO: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int rt_tuse(op_e op);
    case (op)
      BEQ: return 0;
      SW:  return 2;
      ADDU, SUBU, MULT, MULTU, DIV, DIVU: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int dest_of(inst_t i);
    case (i.op)
      ADDU, SUBU, MFHI, MFLO: return int'(i.rd);
      ORI, LUI, LW:           return int'(i.rt);
      JAL:                    return 31;
      default:                return 0;
    endcase
  endfunction

  function automatic int tnew_of(inst_t i, bit in_m);
    if (in_m) return (i.op == LW) ? 1 : 0;
    case (i.op)
      LW: return 2;
      ADDU, SUBU, ORI, LUI, MFHI, MFLO: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit blocks(logic [4:0] src, int tuse, inst_t p, bit in_m);
    int dst;
    dst = dest_of(p);
    return (tuse >= 0) && (dst != 0) && (int'(src) == dst) && (tuse < tnew_of(p, in_m));
  endfunction

  function automatic bit is_md(op_e op);
    return op == MULT || op == MULTU || op == DIV || op == DIVU;
  endfunction

  function automatic bit model_stall(inst_t d, inst_t e, inst_t m);
    bit data, md;
    data = blocks(d.rs, rs_tuse(d.op), e, 1'b0) | blocks(d.rt, rt_tuse(d.op), e, 1'b0) |
           blocks(d.rs, rs_tuse(d.op), m, 1'b1) | blocks(d.rt, rt_tuse(d.op), m, 1'b1);
    md   = (is_md(d.op) || d.op == MFHI || d.op == MFLO) && (is_md(e.op) || busy_left > 0);
    return data | md;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, check mid-cycle, advance the model on the edge.
  task automatic step(inst_t d, inst_t e, inst_t m, bit rst, int exp_stall, int exp_busy,
                      string tag);
    bit st;
    instr_d = enc(d);
    instr_e = enc(e);
    instr_m = enc(m);
    reset   = rst;
    @(negedge clk);
    st = model_stall(d, e, m);
    chk({tag, ".pc_en"},    32'(pc_en),    32'(!st));
    chk({tag, ".ifid_en"},  32'(ifid_en),  32'(!st));
    chk({tag, ".idex_clr"}, 32'(idex_clr), 32'(st));
    chk({tag, ".md_busy"},  32'(md_busy),  32'(busy_left > 0));
    if (exp_stall >= 0) chk({tag, ".stall_dir"}, 32'(idex_clr), 32'(exp_stall));
    if (exp_busy >= 0)  chk({tag, ".busy_dir"},  32'(md_busy),  32'(exp_busy));
`ifdef STALL_STATS_EN
    chk({tag, ".stall_cnt"}, stall_cnt, stats_m);
`endif
    @(posedge clk);
    if (rst) begin
      busy_left = 0;
      stats_m   = 0;
    end else begin
      if (e.op == MULT || e.op == MULTU)   busy_left = MULT_CYC;
      else if (e.op == DIV || e.op == DIVU) busy_left = DIV_CYC;
      else if (busy_left > 0)               busy_left--;
      if (st && stats_m != 32'hFFFF_FFFF) stats_m++;
    end
    #1;
  endtask

  function automatic inst_t rnd_inst(bit for_d);
    int regs[5] = '{0, 1, 2, 3, 31};
    op_e op;
    do op = op_e'($urandom_range(0, 19));
    while (for_d && (op == MTHI || op == MTLO));
    return mk(op, regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
              regs[$urandom_range(0, 4)]);
  endfunction

  initial begin
    inst_t nop;
    nop = mk(NOP, 0, 0, 0);

    step(nop, nop, nop, 1'b1, 0, 0, "reset");
    step(nop, nop, nop, 1'b0, 0, 0, "idle");

    // Load-use: one bubble, then forwarding from M covers it.
    step(mk(ADDU, 1, 3, 2), mk(LW, 0, 1, 0), nop, 1'b0, 1, -1, "lwuse.e");
    step(mk(ADDU, 1, 3, 2), nop, mk(LW, 0, 1, 0), 1'b0, 0, -1, "lwuse.m");
    // ALU result needed by branch in D, but a store can wait for it.
    step(mk(BEQ, 4, 0, 0), mk(ADDU, 5, 6, 4), nop, 1'b0, 1, -1, "alu_beq");
    step(mk(SW, 0, 4, 0), mk(ADDU, 5, 6, 4), nop, 1'b0, 0, -1, "alu_sw");
    step(mk(SW, 0, 1, 0), mk(LW, 0, 1, 0), nop, 1'b0, 0, -1, "lw_sw_rt");
    step(mk(SW, 1, 2, 0), mk(LW, 0, 1, 0), nop, 1'b0, 1, -1, "lw_sw_rs");
    step(mk(BEQ, 1, 0, 0), nop, mk(LW, 0, 1, 0), 1'b0, 1, -1, "lwm_beq");
    step(mk(ADDU, 0, 0, 2), mk(LW, 1, 0, 0), nop, 1'b0, 0, -1, "reg0");
    step(mk(JR, 31, 0, 0), mk(JAL, 0, 0, 0), nop, 1'b0, 0, -1, "jal_jr");
    step(mk(BEQ, 1, 1, 0), mk(UNK, 0, 1, 0), mk(UNK, 0, 1, 0), 1'b0, 0, -1, "unknown");

    // mult window: stall on start plus MULT_CYC busy cycles.
    step(mk(MFLO, 0, 0, 2), mk(MULT, 1, 2, 0), nop, 1'b0, 1, 0, "mult.start");
    for (int k = 0; k < MULT_CYC; k++)
      step(mk(MFLO, 0, 0, 2), nop, nop, 1'b0, 1, 1, "mult.busy");
    step(mk(MFLO, 0, 0, 2), nop, nop, 1'b0, 0, 0, "mult.done");

    // div then reset part way through the count.
    step(nop, mk(DIV, 1, 2, 0), nop, 1'b0, 0, 0, "div.start");
    for (int k = 0; k < 4; k++) step(nop, nop, nop, 1'b0, 0, 1, "div.busy");
    step(mk(MFHI, 0, 0, 3), nop, nop, 1'b1, 1, 1, "div.rst");
    step(mk(MFHI, 0, 0, 3), nop, nop, 1'b0, 0, 0, "div.after");

`ifdef STALL_STATS_EN
    step(nop, nop, nop, 1'b1, 0, 0, "stats.rst0");
    for (int k = 0; k < 3; k++)
      step(mk(ADDU, 1, 3, 2), mk(LW, 0, 1, 0), nop, 1'b0, 1, -1, "stats.lwuse");
    chk("stats.before", stall_cnt, 32'd3);
    step(nop, nop, nop, 1'b1, 0, 0, "stats.rst1");
    chk("stats.after", stall_cnt, 32'd0);
`endif

    // Random mixes with small register set to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      inst_t d, e, m;
      bit r;
      d = rnd_inst(1'b1);
      e = ($urandom_range(0, 3) == 0) ? nop : rnd_inst(1'b0);
      m = ($urandom_range(0, 3) == 0) ? nop : rnd_inst(1'b0);
      r = ($urandom_range(0, 24) == 0);
      step(d, e, m, r, -1, -1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
